// File: rtl/pattern_sequencer.sv
// Playlist-driven controller for frame_gen: steps through (pattern, repeat) entries,
// switching gen_sel only in the gap after a frame ends so every frame has a single pattern.
module pattern_sequencer #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int REP_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [2:0]        cfg_sel,
    input  logic [REP_W-1:0]  cfg_reps,
    input  logic [IDX_W:0]    list_len,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    input  logic              fval,
    output logic              gen_en,
    output logic [2:0]        gen_sel,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [IDX_W-1:0]  cur_idx,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [IDX_W:0]   DEPTH_L = DEPTH[IDX_W:0];
    localparam logic [IDX_W:0]   ONE_I   = 1;
    localparam logic [REP_W:0]   ONE_R   = 1;
    localparam logic [FCNT_W-1:0] ONE_F  = 1;

    state_t              state, state_nx;
    logic                fval_q;
    logic [2:0]          mem_sel  [DEPTH];
    logic [REP_W-1:0]    mem_reps [DEPTH];
    logic [IDX_W:0]      len_q, len_nx;
    logic                loop_q, loop_nx;
    logic                stop_pend, stop_pend_nx;
    logic [REP_W-1:0]    rep_cnt, rep_cnt_nx;
    logic [IDX_W-1:0]    cur_idx_nx, idx_inc;
    logic [FCNT_W-1:0]   frame_cnt_nx;
    logic                gen_en_nx, done_nx, cfg_err_nx, mem_wr;
    logic [2:0]          gen_sel_nx;
    logic                fs, fe, last_rep, last_entry;
    logic [REP_W:0]      rep_lim;

    assign fs         = fval & ~fval_q;
    assign fe         = ~fval & fval_q;
    assign busy       = (state != IDLE);
    assign idx_inc    = cur_idx + 1'b1;
    assign rep_lim    = (mem_reps[cur_idx] == '0) ? ONE_R : {1'b0, mem_reps[cur_idx]};
    assign last_rep   = ({1'b0, rep_cnt} + ONE_R) >= rep_lim;
    assign last_entry = ({1'b0, cur_idx} + ONE_I) >= len_q;

    always_comb begin
        state_nx     = state;
        len_nx       = len_q;
        loop_nx      = loop_q;
        stop_pend_nx = stop_pend;
        rep_cnt_nx   = rep_cnt;
        cur_idx_nx   = cur_idx;
        frame_cnt_nx = frame_cnt;
        gen_en_nx    = gen_en;
        gen_sel_nx   = gen_sel;
        done_nx      = 1'b0;
        cfg_err_nx   = cfg_we & (state != IDLE);
        mem_wr       = cfg_we & (state == IDLE);
        case (state)
            IDLE: begin
                if (start && (list_len != '0) && !stop) begin
                    // Oversized lengths are clamped so the index never leaves the table.
                    len_nx       = (list_len > DEPTH_L) ? DEPTH_L : list_len;
                    loop_nx      = loop;
                    stop_pend_nx = 1'b0;
                    rep_cnt_nx   = '0;
                    cur_idx_nx   = '0;
                    frame_cnt_nx = '0;
                    gen_sel_nx   = mem_sel[0];
                    gen_en_nx    = 1'b1;
                    state_nx     = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    gen_en_nx = 1'b0;
                    done_nx   = 1'b1;
                    state_nx  = IDLE;
                end else if (fs) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop)
                    stop_pend_nx = 1'b1;
                if (fe) begin
                    frame_cnt_nx = (&frame_cnt) ? frame_cnt : frame_cnt + ONE_F;
                    if (stop || stop_pend || (last_rep && last_entry && !loop_q)) begin
                        gen_en_nx    = 1'b0;
                        done_nx      = 1'b1;
                        stop_pend_nx = 1'b0;
                        state_nx     = IDLE;
                    end else if (!last_rep) begin
                        rep_cnt_nx = rep_cnt + 1'b1;
                    end else begin
                        rep_cnt_nx = '0;
                        cur_idx_nx = last_entry ? '0 : idx_inc;
                        gen_sel_nx = last_entry ? mem_sel[0] : mem_sel[idx_inc];
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fval_q    <= 1'b0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            stop_pend <= 1'b0;
            rep_cnt   <= '0;
            cur_idx   <= '0;
            frame_cnt <= '0;
            gen_en    <= 1'b0;
            gen_sel   <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            fval_q    <= fval;
            len_q     <= len_nx;
            loop_q    <= loop_nx;
            stop_pend <= stop_pend_nx;
            rep_cnt   <= rep_cnt_nx;
            cur_idx   <= cur_idx_nx;
            frame_cnt <= frame_cnt_nx;
            gen_en    <= gen_en_nx;
            gen_sel   <= gen_sel_nx;
            done      <= done_nx;
            cfg_err   <= cfg_err_nx;
        end
    end

    // Playlist table; cleared on reset so an unprogrammed entry plays pattern 0 once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_sel[i]  <= '0;
                mem_reps[i] <= '0;
            end
        end else if (mem_wr) begin
            mem_sel[cfg_addr]  <= cfg_sel;
            mem_reps[cfg_addr] <= cfg_reps;
        end
    end

endmodule
